tmem_mp: RTL and testbench
==========================

Name: tmem_mp

Overview:
- Parametrised, multi-lane twiddle-factor memory for the FFT datapath. Next generation of the fixed 16-entry, 24-bit dual-port twiddle store.
- Twiddles are loaded once through a valid/ready stream. Every lane receives its own replicated copy.
- Each of NUM_LANES butterfly lanes reads independently with 2-cycle latency.
- Supports stage-based address generation and an inverse-FFT conjugate mode.
- Sits between the host configuration path and the butterfly units.

Parameters:
- TW_WIDTH, 24: twiddle word width. Real part in [TW_WIDTH-1:TW_WIDTH/2], imag in [TW_WIDTH/2-1:0]. Must be even.
- DEPTH, 16: entries per lane copy. Power of two, >=4.
- NUM_LANES, 2: independent read lanes; each holds a full replica.
- ADDR_W, $clog2(DEPTH): derived localparam, not overridable.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ld_start  in  1  pulse: begin load of DEPTH words
- ld_valid  in  1  load word valid
- ld_ready  out  1  block accepts load word
- ld_data  in  TW_WIDTH  load word; beat k writes entry k of all lanes
- load_done  out  1  level: table valid, reads permitted
- busy  out  1  level: load in progress
- rd_en  in  NUM_LANES  per-lane read request
- rd_mode  in  1  0 = direct address, 1 = stage address
- rd_stage  in  ADDR_W  stage shift (used when rd_mode=1)
- rd_idx  in  NUM_LANES*ADDR_W  per-lane address or butterfly index (lane i at [i*ADDR_W +: ADDR_W])
- inv  in  1  1 = conjugate output (inverse FFT)
- rd_valid  out  NUM_LANES  per-lane data valid
- rd_data  out  NUM_LANES*TW_WIDTH  per-lane twiddle
- err  out  1  sticky protocol error
- err_clr  in  1  clears err

Behaviour:
- Reset values (async, rst_n low): state=IDLE, ld_ready=0, busy=0, load_done=0, rd_valid=0, rd_data=0, err=0, load counter=0. Storage array is not reset; contents are undefined after reset.
- FSM has three states:
  - IDLE: ld_start -> LOAD.
  - LOAD: ld_ready=1, busy=1. Each cycle with ld_valid&ld_ready writes ld_data to entry cnt in every lane and increments cnt. The beat at cnt=DEPTH-1 -> READY, with cnt wrapping to 0.
  - READY: load_done=1. ld_start -> LOAD, dropping load_done the next cycle. Existing table is overwritten progressively.
- ld_start in LOAD: ignored, err set. ld_valid outside LOAD: ignored, err set. ld_ready is combinationally equal to (state==LOAD).
- Read address per lane:
  - rd_mode=0: addr = rd_idx_i.
  - rd_mode=1: addr = (rd_idx_i << rd_stage) truncated to ADDR_W bits (mod DEPTH wrap-around).
- Read pipeline:
  - Cycle 0: rd_en_i sampled; address and inv registered.
  - Cycle 1: array read registered.
  - Cycle 2: rd_valid_i=1 with rd_data_i.
  - Latency is exactly 2. Full throughput: one read per lane per cycle. Lanes are independent.
- rd_en_i when state!=READY: request dropped (no rd_valid), err set. Requests already in flight when ld_start arrives complete normally with pre-load data.
- rd_en_i=0: rd_valid_i=0 in the corresponding cycle; rd_data_i holds its last value.
- Conjugate (inv registered with request): imag_out = -imag. The most negative imag value saturates to the most positive, e.g. 12-bit 0x800 -> 0x7FF. Real part is unchanged.
- err: set by any error event. err_clr clears it; a simultaneous set wins over clear.
- Reset mid-load: FSM returns to IDLE and load_done=0. A full reload is required before reads.

Test Plan:
- Reset then load entry k = {12'(k), 12'(k+0x100)} for k=0..15 with ld_valid always high. Required: ld_ready high for 16 cycles; load_done=1 on the cycle after beat 15; busy=0.
- Load with ld_valid toggling 1,0,1,0. Required: exactly 16 accepted beats; load_done asserted after beat 16, not before; contents verified by direct reads.
- Direct reads, lane0 addr 3 and lane1 addr 15 on the same cycle, continuous for 4 cycles. Required: rd_valid both high from cycle 2; data 0x003103 and 0x00F10F; back-to-back throughput.
- Stage mode with rd_stage=2 and rd_idx=5. Required: addr = 20 mod 16 = 4, returning 0x004104. With rd_stage=3 and idx=3: addr 8.
- inv=1 on entry loaded as 0x123800. Required: 0x1237FF (saturated). On 0x0050FF: 0x005F01.
- Read before any load, ld_start during LOAD, then err_clr. Required: no rd_valid, err=1 and sticky; err_clr returns err to 0. Also assert rst_n low mid-load: load_done=0, ld_ready=0 immediately.

Source files
------------

// File: rtl/tmem_mp.sv
// Multi-lane twiddle-factor memory: stream-loaded once, each lane holds a replica
// and reads independently with two-cycle latency, stage addressing and conjugation.
module tmem_mp #(
    parameter int TW_WIDTH  = 24,
    parameter int DEPTH     = 16,
    parameter int NUM_LANES = 2,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ld_start,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [TW_WIDTH-1:0]           ld_data,
    output logic                          load_done,
    output logic                          busy,
    input  logic [NUM_LANES-1:0]          rd_en,
    input  logic                          rd_mode,
    input  logic [ADDR_W-1:0]             rd_stage,
    input  logic [NUM_LANES*ADDR_W-1:0]   rd_idx,
    input  logic                          inv,
    output logic [NUM_LANES-1:0]          rd_valid,
    output logic [NUM_LANES*TW_WIDTH-1:0] rd_data,
    output logic                          err,
    input  logic                          err_clr
);
    localparam int HALF = TW_WIDTH / 2;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   cnt_reg;
    logic                err_reg;
    logic                err_set;
    logic                wr_en;
    logic                rd_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (wr_en)
                cnt_reg <= cnt_reg + 1'b1;
            if (err_set)
                err_reg <= 1'b1;
            else if (err_clr)
                err_reg <= 1'b0;
        end
    end

    always_comb begin
        state_next = state_reg;
        ld_ready   = 1'b0;
        busy       = 1'b0;
        load_done  = 1'b0;
        err_set    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (ld_start)
                    state_next = S_LOAD;
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                busy     = 1'b1;
                if (ld_start)
                    err_set = 1'b1;
                if (ld_valid && cnt_reg == ADDR_W'(DEPTH - 1))
                    state_next = S_READY;
            end
            S_READY: begin
                load_done = 1'b1;
                if (ld_start)
                    state_next = S_LOAD;
            end
            default: state_next = S_IDLE;
        endcase
        if (ld_valid && state_reg != S_LOAD)
            err_set = 1'b1;
        if ((|rd_en) && state_reg != S_READY)
            err_set = 1'b1;
    end

    assign wr_en     = ld_valid && (state_reg == S_LOAD);
    assign rd_accept = (state_reg == S_READY);
    assign err       = err_reg;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [TW_WIDTH-1:0] mem [DEPTH];
            logic [ADDR_W-1:0]   idx;
            logic [ADDR_W-1:0]   addr_next;
            logic [ADDR_W-1:0]   addr_reg;
            logic                en_reg;
            logic                inv_reg;
            logic                valid_reg;
            logic [TW_WIDTH-1:0] data_reg;
            logic [TW_WIDTH-1:0] word;
            logic [HALF-1:0]     imag;
            logic [HALF-1:0]     imag_conj;

            assign idx       = rd_idx[gi*ADDR_W +: ADDR_W];
            assign addr_next = rd_mode ? ADDR_W'(idx << rd_stage) : idx;

            always_ff @(posedge clk) begin
                if (wr_en)
                    mem[cnt_reg] <= ld_data;
            end

            assign word = mem[addr_reg];
            assign imag = word[HALF-1:0];
            // Negating the most negative value would overflow; clamp to most positive.
            assign imag_conj = (imag == {1'b1, {(HALF-1){1'b0}}}) ?
                               {1'b0, {(HALF-1){1'b1}}} : (~imag) + HALF'(1);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    en_reg    <= 1'b0;
                    addr_reg  <= '0;
                    inv_reg   <= 1'b0;
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else begin
                    en_reg <= rd_en[gi] && rd_accept;
                    if (rd_en[gi]) begin
                        addr_reg <= addr_next;
                        inv_reg  <= inv;
                    end
                    valid_reg <= en_reg;
                    if (en_reg)
                        data_reg <= inv_reg ? {word[TW_WIDTH-1:HALF], imag_conj} : word;
                end
            end

            assign rd_valid[gi]                      = valid_reg;
            assign rd_data[gi*TW_WIDTH +: TW_WIDTH]  = data_reg;
        end
    endgenerate
endmodule

// File: tb/tb_tmem_mp.sv
// Directed testbench for tmem_mp: load protocol, direct/stage reads, conjugation, errors.
module tb_tmem_mp;
    localparam int TW = 24;
    localparam int DEPTH = 16;
    localparam int NL = 2;
    localparam int AW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ld_start, ld_valid, ld_ready;
    logic [TW-1:0]  ld_data;
    logic           load_done, busy;
    logic [NL-1:0]  rd_en;
    logic           rd_mode;
    logic [AW-1:0]  rd_stage;
    logic [NL*AW-1:0] rd_idx;
    logic           inv;
    logic [NL-1:0]  rd_valid;
    logic [NL*TW-1:0] rd_data;
    logic           err, err_clr;

    int checks = 0;
    int passed = 0;

    tmem_mp #(.TW_WIDTH(TW), .DEPTH(DEPTH), .NUM_LANES(NL)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .load_done(load_done), .busy(busy),
        .rd_en(rd_en), .rd_mode(rd_mode), .rd_stage(rd_stage), .rd_idx(rd_idx), .inv(inv),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [TW-1:0] tw_val(input int k, input bit alt);
        if (alt && k == 6) return 24'h123800;
        if (alt && k == 7) return 24'h0050FF;
        return {12'(k), 12'(k + 'h100)};
    endfunction

    // One-cycle read request; returns at the sample point two cycles later.
    task automatic do_read(input logic [1:0] en, input logic mode, input logic [3:0] stage,
                           input logic [3:0] i0, input logic [3:0] i1, input logic iv);
        @(negedge clk);
        rd_en = en; rd_mode = mode; rd_stage = stage; rd_idx = {i1, i0}; inv = iv;
        @(negedge clk);
        rd_en = '0; inv = 1'b0; rd_mode = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_table(input bit alt);
        @(negedge clk); ld_start = 1'b1;
        @(negedge clk); ld_start = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            ld_valid = 1'b1; ld_data = tw_val(k, alt);
            @(negedge clk);
        end
        ld_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (ld_ready !== 1'b0) $display("FAIL reset_ld_ready: got %b expected 0", ld_ready); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        checks++; if (load_done !== 1'b0) $display("FAIL reset_load_done: got %b expected 0", load_done); else passed++;
        checks++; if (rd_valid !== 2'b00) $display("FAIL reset_rd_valid: got %b expected 00", rd_valid); else passed++;
        checks++; if (rd_data !== 48'h0) $display("FAIL reset_rd_data: got %h expected 0", rd_data); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_read_before_load;
        do_read(2'b11, 1'b0, 4'd0, 4'd3, 4'd15, 1'b0);
        checks++; if (rd_valid !== 2'b00) $display("FAIL early_read_valid: got %b expected 00", rd_valid); else passed++;
        checks++; if (err !== 1'b1) $display("FAIL early_read_err: got %b expected 1", err); else passed++;
        repeat (3) @(negedge clk);
        checks++; if (err !== 1'b1) $display("FAIL err_sticky: got %b expected 1", err); else passed++;
        err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        checks++; if (err !== 1'b0) $display("FAIL err_clr: got %b expected 0", err); else passed++;
    endtask

    task automatic test_load_cont;
        int ready_cnt = 0;
        int early = 0;
        @(negedge clk); ld_start = 1'b1;
        @(negedge clk); ld_start = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            ld_valid = 1'b1; ld_data = tw_val(k, 1'b0);
            if (ld_ready === 1'b1) ready_cnt++;
            if (load_done !== 1'b0) early++;
            @(negedge clk);
        end
        ld_valid = 1'b0;
        checks++; if (ready_cnt != 16) $display("FAIL load_ready_cycles: got %0d expected 16", ready_cnt); else passed++;
        checks++; if (early != 0) $display("FAIL load_done_early: got %0d cycles expected 0", early); else passed++;
        checks++; if (load_done !== 1'b1) $display("FAIL load_done: got %b expected 1", load_done); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL load_busy_after: got %b expected 0", busy); else passed++;
        checks++; if (ld_ready !== 1'b0) $display("FAIL load_ready_after: got %b expected 0", ld_ready); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL load_err: got %b expected 0", err); else passed++;
    endtask

    task automatic test_direct_reads;
        logic exp_v;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            exp_v = (i >= 2 && i <= 5);
            checks++;
            if (rd_valid !== {exp_v, exp_v}) $display("FAIL direct_valid_c%0d: got %b expected %b", i, rd_valid, {exp_v, exp_v});
            else passed++;
            if (i >= 2) begin
                checks++;
                if (rd_data !== {24'h00F10F, 24'h003103}) $display("FAIL direct_data_c%0d: got %h expected 00f10f003103", i, rd_data);
                else passed++;
            end
            rd_en = (i < 4) ? 2'b11 : 2'b00;
            rd_mode = 1'b0; inv = 1'b0; rd_idx = {4'd15, 4'd3};
        end
        // Lane 0 alone: lane 1 must stay idle and hold its last word.
        do_read(2'b01, 1'b0, 4'd0, 4'd4, 4'd0, 1'b0);
        checks++; if (rd_valid !== 2'b01) $display("FAIL lane_indep_valid: got %b expected 01", rd_valid); else passed++;
        checks++; if (rd_data !== {24'h00F10F, 24'h004104}) $display("FAIL lane_indep_data: got %h expected 00f10f004104", rd_data); else passed++;
    endtask

    task automatic test_stage;
        do_read(2'b11, 1'b1, 4'd2, 4'd5, 4'd3, 1'b0);
        checks++; if (rd_data !== {24'h00C10C, 24'h004104}) $display("FAIL stage2: got %h expected 00c10c004104", rd_data); else passed++;
        do_read(2'b11, 1'b1, 4'd3, 4'd3, 4'd5, 1'b0);
        checks++; if (rd_data !== {24'h008108, 24'h008108}) $display("FAIL stage3: got %h expected 008108008108", rd_data); else passed++;
    endtask

    task automatic test_load_toggle;
        int acc = 0;
        int cyc = 0;
        int early = 0;
        @(negedge clk); ld_start = 1'b1;
        @(negedge clk); ld_start = 1'b0;
        checks++; if (load_done !== 1'b0) $display("FAIL reload_drop_done: got %b expected 0", load_done); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL reload_busy: got %b expected 1", busy); else passed++;
        while (acc < 16 && cyc < 64) begin
            if (load_done !== 1'b0) early++;
            ld_valid = (cyc % 2 == 0);
            ld_data = tw_val(acc, 1'b1);
            if (ld_valid && ld_ready === 1'b1) acc++;
            cyc++;
            @(negedge clk);
        end
        ld_valid = 1'b0;
        checks++; if (acc != 16 || cyc != 31) $display("FAIL toggle_beats: got %0d beats in %0d cycles expected 16 in 31", acc, cyc); else passed++;
        checks++; if (early != 0) $display("FAIL toggle_done_early: got %0d expected 0", early); else passed++;
        checks++; if (load_done !== 1'b1) $display("FAIL toggle_done: got %b expected 1", load_done); else passed++;
        do_read(2'b11, 1'b0, 4'd0, 4'd3, 4'd6, 1'b0);
        checks++; if (rd_data !== {24'h123800, 24'h003103}) $display("FAIL toggle_data_a: got %h expected 123800003103", rd_data); else passed++;
        do_read(2'b11, 1'b0, 4'd0, 4'd15, 4'd7, 1'b0);
        checks++; if (rd_data !== {24'h0050FF, 24'h00F10F}) $display("FAIL toggle_data_b: got %h expected 0050ff00f10f", rd_data); else passed++;
    endtask

    task automatic test_inv;
        do_read(2'b11, 1'b0, 4'd0, 4'd6, 4'd7, 1'b1);
        checks++; if (rd_data !== {24'h005F01, 24'h1237FF}) $display("FAIL inv_sat: got %h expected 005f011237ff", rd_data); else passed++;
        do_read(2'b11, 1'b0, 4'd0, 4'd3, 4'd15, 1'b1);
        checks++; if (rd_data !== {24'h00FEF1, 24'h003EFD}) $display("FAIL inv_plain: got %h expected 00fef1003efd", rd_data); else passed++;
        do_read(2'b01, 1'b0, 4'd0, 4'd6, 4'd0, 1'b0);
        checks++; if (rd_data[23:0] !== 24'h123800) $display("FAIL inv_off: got %h expected 123800", rd_data[23:0]); else passed++;
    endtask

    task automatic test_errors;
        @(negedge clk); ld_valid = 1'b1;
        @(negedge clk); ld_valid = 1'b0;
        checks++; if (err !== 1'b1) $display("FAIL valid_outside_load: got %b expected 1", err); else passed++;
        checks++; if (load_done !== 1'b1) $display("FAIL valid_ignored: got %b expected 1", load_done); else passed++;
        ld_valid = 1'b1; err_clr = 1'b1;
        @(negedge clk); ld_valid = 1'b0; err_clr = 1'b0;
        checks++; if (err !== 1'b1) $display("FAIL set_beats_clear: got %b expected 1", err); else passed++;
        err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        checks++; if (err !== 1'b0) $display("FAIL err_clr2: got %b expected 0", err); else passed++;
        ld_start = 1'b1;
        @(negedge clk);
        @(negedge clk); ld_start = 1'b0;
        checks++; if (err !== 1'b1) $display("FAIL start_in_load: got %b expected 1", err); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL start_in_load_busy: got %b expected 1", busy); else passed++;
        for (int k = 0; k < 3; k++) begin
            ld_valid = 1'b1; ld_data = 24'hFFFFFF;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (load_done !== 1'b0) $display("FAIL midload_rst_done: got %b expected 0", load_done); else passed++;
        checks++; if (ld_ready !== 1'b0) $display("FAIL midload_rst_ready: got %b expected 0", ld_ready); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL midload_rst_busy: got %b expected 0", busy); else passed++;
        @(negedge clk); rst_n = 1'b1; ld_valid = 1'b0;
        do_read(2'b11, 1'b0, 4'd0, 4'd3, 4'd15, 1'b0);
        checks++; if (rd_valid !== 2'b00) $display("FAIL read_after_rst_valid: got %b expected 00", rd_valid); else passed++;
        checks++; if (err !== 1'b1) $display("FAIL read_after_rst_err: got %b expected 1", err); else passed++;
        err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
    endtask

    task automatic test_back_to_back;
        load_table(1'b0);
        @(negedge clk);
        rd_en = 2'b01; rd_idx = {4'd0, 4'd0}; rd_mode = 1'b0; inv = 1'b0; ld_start = 1'b1;
        @(negedge clk);
        rd_en = 2'b00; ld_start = 1'b0; ld_valid = 1'b1; ld_data = 24'hABCDEF;
        @(negedge clk);
        ld_valid = 1'b0;
        checks++; if (rd_valid !== 2'b01) $display("FAIL inflight_valid: got %b expected 01", rd_valid); else passed++;
        checks++; if (rd_data[23:0] !== 24'h000100) $display("FAIL inflight_data: got %h expected 000100", rd_data[23:0]); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL inflight_err: got %b expected 0", err); else passed++;
    endtask

    initial begin
        rst_n = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
        rd_en = '0; rd_mode = 1'b0; rd_stage = '0; rd_idx = '0; inv = 1'b0; err_clr = 1'b0;
        test_reset;
        test_read_before_load;
        test_load_cont;
        test_direct_reads;
        test_stage;
        test_load_toggle;
        test_inv;
        test_errors;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
